// File: rtl/write_data_beat_tx_if.sv
// Bundle of request, beat-stream and retry signals for the tagged write-data beat link.
// master: the transmitter; slave: the requester/sink side.
interface write_data_beat_tx_if #(
   parameter int unsigned BEATS  = 16,
   parameter int unsigned BEAT_W = 8,
   parameter int unsigned TAG_W  = 4
);
   logic                      write_request;
   logic [0:BEATS*BEAT_W-1]   model_data;
   logic                      data_ready;
   logic                      retry;
   logic [TAG_W-1:0]          retry_tag;
   logic                      write_request_ack;
   logic [TAG_W-1:0]          write_request_ack_tag;
   logic                      data_valid;
   logic [TAG_W-1:0]          data_valid_tag;
   logic [BEAT_W-1:0]         data;
   logic                      last_data_valid;
   logic                      busy;

   modport master (
      input  write_request, model_data, data_ready, retry, retry_tag,
      output write_request_ack, write_request_ack_tag, data_valid, data_valid_tag, data,
             last_data_valid, busy
   );

   modport slave (
      output write_request, model_data, data_ready, retry, retry_tag,
      input  write_request_ack, write_request_ack_tag, data_valid, data_valid_tag, data,
             last_data_valid, busy
   );
endinterface

// File: rtl/write_data_beat_tx.sv
// Transmit side of the tagged write-data beat protocol: acknowledges a request with a tag,
// latches the payload and streams it beat by beat, restarting on a matching retry.
module write_data_beat_tx #(
   parameter int unsigned BEATS  = 16,
   parameter int unsigned BEAT_W = 8,
   parameter int unsigned TAG_W  = 4
) (
   input logic                  clk,
   input logic                  reset,
   write_data_beat_tx_if.master bus
);

   localparam int unsigned      CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned      PAY_W     = BEATS * BEAT_W;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {StIdle, StAck, StSend, StWin} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   beat_q, beat_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [0:PAY_W-1]   payload_q, payload_d;
   logic [BEAT_W-1:0]  beat_mem [BEATS];
   logic               retry_hit;
   logic               last_beat;

   // A retry only counts when it names the transfer currently in flight.
   assign retry_hit = bus.retry && (bus.retry_tag == tag_q);
   assign last_beat = (beat_q == LAST_BEAT);

   // Beat view of the payload; beat 0 is the leftmost (lowest-index) slice.
   always_comb begin
      for (int i = 0; i < int'(BEATS); i++) begin
         beat_mem[i] = payload_q[i*BEAT_W +: BEAT_W];
      end
   end

   // State register together with the beat counter, tag and payload datapath.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         beat_q    <= '0;
         tag_q     <= '0;
         payload_q <= '0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         tag_q     <= tag_d;
         payload_q <= payload_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      tag_d     = tag_q;
      payload_d = payload_q;
      unique case (state_q)
         StIdle: begin
            if (bus.write_request) begin
               state_d = StAck;
            end
         end
         StAck: begin
            // Requester may withdraw during the ack cycle; tag is kept for the next attempt.
            if (bus.write_request) begin
               payload_d = bus.model_data;
               beat_d    = '0;
               state_d   = StSend;
            end else begin
               state_d = StIdle;
            end
         end
         StSend: begin
            if (retry_hit) begin
               beat_d = '0;
            end else if (bus.data_ready) begin
               if (last_beat) begin
                  state_d = StWin;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         StWin: begin
            // Last chance for the sink to ask for a resend before the tag moves on.
            if (retry_hit) begin
               beat_d  = '0;
               state_d = StSend;
            end else begin
               tag_d   = tag_q + 1'b1;
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs decoded purely from registered state.
   always_comb begin
      bus.write_request_ack     = 1'b0;
      bus.write_request_ack_tag = '0;
      bus.data_valid            = 1'b0;
      bus.data_valid_tag        = '0;
      bus.data                  = '0;
      bus.last_data_valid       = 1'b0;
      bus.busy                  = (state_q != StIdle);
      unique case (state_q)
         StAck: begin
            bus.write_request_ack     = 1'b1;
            bus.write_request_ack_tag = tag_q;
         end
         StSend: begin
            bus.data_valid      = 1'b1;
            bus.data_valid_tag  = tag_q;
            bus.data            = beat_mem[beat_q];
            bus.last_data_valid = last_beat;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_write_data_beat_tx.sv
// Bench for write_data_beat_tx: directed protocol scenarios plus randomized transfers,
// checked against a transfer-level model of the beat stream.
module tb_write_data_beat_tx;

   localparam int unsigned BEATS  = 16;
   localparam int unsigned BEAT_W = 8;
   localparam int unsigned TAG_W  = 4;

   logic clk;
   logic reset;

   write_data_beat_tx_if #(.BEATS(BEATS), .BEAT_W(BEAT_W), .TAG_W(TAG_W)) bus ();

   write_data_beat_tx #(.BEATS(BEATS), .BEAT_W(BEAT_W), .TAG_W(TAG_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // Model of the transfer in flight.
   logic [7:0] exp_bytes [BEATS];
   int         exp_tag = 0;
   int         idx     = 0;
   bit         in_win  = 1'b0;
   bit         idle    = 1'b1;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk_quiet(input string name);
      chk(name, 32'({bus.write_request_ack, bus.write_request_ack_tag, bus.data_valid,
                     bus.data_valid_tag, bus.data, bus.last_data_valid, bus.busy}), 32'd0);
   endtask

   // Request a transfer of p; checks the ack cycle and leaves the DUT on beat 0.
   task automatic start(input logic [127:0] p);
      for (int i = 0; i < int'(BEATS); i++) begin
         exp_bytes[i] = 8'(p >> (8 * (int'(BEATS) - 1 - i)));
      end
      bus.model_data    = p;
      bus.write_request = 1'b1;
      tick();
      chk("ack", 32'({bus.write_request_ack, bus.data_valid, bus.busy}), 32'b101);
      chk("ack_tag", 32'(bus.write_request_ack_tag), 32'(exp_tag % 16));
      tick();
      bus.write_request = 1'b0;
      // Payload must already be latched; scramble the input to prove it.
      bus.model_data    = {$urandom, $urandom, $urandom, $urandom};
      idx    = 0;
      in_win = 1'b0;
      idle   = 1'b0;
   endtask

   // Check the current cycle against the model, apply sink inputs, advance one clock.
   task automatic step(input logic rdy, input logic rty, input logic [3:0] rtag);
      bit match;
      if (in_win) begin
         chk("win_cycle", 32'({bus.data_valid, bus.last_data_valid, bus.write_request_ack,
                              bus.busy}), 32'b0001);
      end else begin
         chk("beat_flags", 32'({bus.data_valid, bus.last_data_valid, bus.write_request_ack,
                               bus.busy}), 32'({1'b1, idx == int'(BEATS) - 1, 1'b0, 1'b1}));
         chk("beat_data", 32'(bus.data), 32'(exp_bytes[idx]));
         chk("beat_tag", 32'(bus.data_valid_tag), 32'(exp_tag % 16));
      end
      bus.data_ready = rdy;
      bus.retry      = rty;
      bus.retry_tag  = rtag;
      tick();
      match = rty && (int'(rtag) == exp_tag % 16);
      if (in_win) begin
         in_win = 1'b0;
         if (match) begin
            idx = 0;
         end else begin
            idle = 1'b1;
            exp_tag++;
         end
      end else if (match) begin
         idx = 0;
      end else if (rdy) begin
         if (idx == int'(BEATS) - 1) in_win = 1'b1;
         else idx++;
      end
      bus.retry = 1'b0;
   endtask

   // Drive the transfer to completion, either with a steady sink or randomized behaviour.
   task automatic run(input bit rnd);
      int guard = 0;
      while (!idle && guard < 2000) begin
         if (rnd) begin
            step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 4,
                 ($urandom_range(0, 1) != 0) ? 4'(exp_tag % 16) : 4'($urandom_range(0, 15)));
         end else begin
            step(1'b1, 1'b0, 4'd0);
         end
         guard++;
      end
      chk("done_in_budget", 32'(idle), 32'd1);
      chk_quiet("idle_after_transfer");
   endtask

   initial begin
      int c0;
      logic [127:0] basic;
      basic = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      reset             = 1'b0;
      bus.write_request = 1'b0;
      bus.model_data    = '0;
      bus.data_ready    = 1'b0;
      bus.retry         = 1'b0;
      bus.retry_tag     = '0;

      // Reset state, observed before any clock edge.
      #2 reset = 1'b1;
      #1 chk_quiet("reset_state");
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk_quiet("after_reset_release");

      // Basic transfer with minimum latency, then a late retry in IDLE is ignored.
      c0 = cyc;
      start(basic);
      run(1'b0);
      chk("min_transfer_cycles", 32'(cyc - c0), 32'(BEATS + 3));
      bus.retry     = 1'b1;
      bus.retry_tag = 4'((exp_tag - 1) % 16);
      tick();
      bus.retry     = 1'b0;
      chk_quiet("retry_in_idle_ignored");

      // Backpressure on beat 5.
      start(basic);
      repeat (5) step(1'b1, 1'b0, 4'd0);
      repeat (3) step(1'b0, 1'b0, 4'd0);
      chk("bp_resume_idx", 32'(idx), 32'd5);
      run(1'b0);

      // Matching retry at beat 7 restarts; non-matching retry at beat 7 is ignored.
      start(basic);
      repeat (7) step(1'b1, 1'b0, 4'd0);
      step(1'b1, 1'b1, 4'(exp_tag % 16));
      repeat (7) step(1'b1, 1'b0, 4'd0);
      step(1'b1, 1'b1, 4'((exp_tag + 1) % 16));
      run(1'b0);

      // Matching retry in the WIN cycle resends everything with the same tag.
      start(basic);
      for (int k = 0; k < 40 && !in_win; k++) step(1'b1, 1'b0, 4'd0);
      chk("reached_win", 32'(in_win), 32'd1);
      step(1'b1, 1'b1, 4'(exp_tag % 16));
      run(1'b0);

      // Reset during beat 9 drops the transfer immediately and clears the tag.
      start(basic);
      repeat (9) step(1'b1, 1'b0, 4'd0);
      reset = 1'b1;
      #1 chk_quiet("async_reset_mid_transfer");
      tick();
      reset   = 1'b0;
      exp_tag = 0;
      idle    = 1'b1;
      in_win  = 1'b0;
      tick();
      chk_quiet("after_mid_reset");

      // Withdrawal during the ack cycle.
      bus.model_data    = {$urandom, $urandom, $urandom, $urandom};
      bus.write_request = 1'b1;
      tick();
      chk("withdraw_ack", 32'({bus.write_request_ack, bus.write_request_ack_tag}),
          32'({1'b1, 4'(exp_tag % 16)}));
      bus.write_request = 1'b0;
      tick();
      chk_quiet("withdraw_idle");

      // Sixteen randomized transfers walk the tag through 0..15; the 17th wraps to 0.
      for (int t = 0; t < 16; t++) begin
         start({$urandom, $urandom, $urandom, $urandom});
         run(1'b1);
      end
      chk("tags_consumed", 32'(exp_tag), 32'd16);
      start({$urandom, $urandom, $urandom, $urandom});
      run(1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
